// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute stage: single-cycle ALU plus iterative shift-add multiplier
// Optional feature macro EXEC_MUL_EN builds the multiplier; without it op=111 pulses illegal.
module exec_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    dst,
    output logic             busy,
    output logic             we,
    output logic [AW-1:0]    wa,
    output logic [WIDTH-1:0] wd,
    output logic             illegal
);

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WB} state_t;
`endif

    localparam logic [2:0] OP_MUL = 3'b111;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] alu_res;

    assign accept = start && (state == S_IDLE);
    assign is_mul = (op == OP_MUL);
    assign busy   = (state != S_IDLE);
    assign we     = (state == S_WB);

    always_comb begin
        alu_res = '0;
        case (op)
            3'b000:  alu_res = a + b;
            3'b001:  alu_res = a - b;
            3'b010:  alu_res = a & b;
            3'b011:  alu_res = a | b;
            3'b100:  alu_res = a ^ b;
            3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b110:  alu_res = a << b[4:0];
            default: alu_res = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] acc_sum;

    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign illegal = 1'b0;
`else
    logic illegal_q;
    assign illegal = illegal_q;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef EXEC_MUL_EN
                    state_nx = is_mul ? S_MUL : S_WB;
`else
                    state_nx = is_mul ? S_IDLE : S_WB;
`endif
                end
            end
`ifdef EXEC_MUL_EN
            S_MUL:   if (cnt == 5'd31) state_nx = S_WB;
`endif
            S_WB:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wa <= '0;
            wd <= '0;
        end else if (accept && !is_mul) begin
            wa <= dst;
            wd <= alu_res;
`ifdef EXEC_MUL_EN
        end else if (accept) begin
            wa <= dst;
        end else if (state == S_MUL && cnt == 5'd31) begin
            wd <= acc_sum;
`endif
        end
    end

`ifdef EXEC_MUL_EN
    // One shift-add step per cycle; the 32nd step's sum goes straight to wd.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
        end
    end
`else
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) illegal_q <= 1'b0;
        else        illegal_q <= accept && is_mul;
    end
`endif

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - scoreboard bench for exec_unit with a cycle-level reference model
module tb_exec_unit;

`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  dst = '0;
    logic        busy, we, illegal;
    logic [2:0]  wa;
    logic [31:0] wd;

    exec_unit #(.WIDTH(32), .AW(3)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
        .busy(busy), .we(we), .wa(wa), .wd(wd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          ill;
        logic [2:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   free_at = 0;
    int   bs = 1;
    int   be = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return x ^ y;
            3'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd6:    return x << y[4:0];
            default: return x * y;
        endcase
    endfunction

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs and, if the model says the unit is free, predict the response.
    task automatic drive(input bit s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] d);
        exp_t e;
        int   e0;
        @(posedge clk);
        #2;
        start = s; op = o; a = x; b = y; dst = d;
        e0 = cyc + 1;
        if (s && e0 >= free_at) begin
            e.wa = d;
            e.wd = ref_op(o, x, y);
            e.ill = 1'b0;
            if (o == 3'd7 && !MUL_EN) begin
                e.ill = 1'b1; e.cyc = e0; free_at = e0 + 1;
            end else if (o == 3'd7) begin
                e.cyc = e0 + 32; bs = e0; be = e0 + 32; free_at = e0 + 34;
            end else begin
                e.cyc = e0; bs = e0; be = e0; free_at = e0 + 2;
            end
            q.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [2:0] d);
        while (cyc + 1 < free_at) idle();
        drive(1'b1, o, x, y, d);
        idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(busy == 1'b0, {tag, "_busy"}, 32'(busy), 32'd0);
        check(we == 1'b0, {tag, "_we"}, 32'(we), 32'd0);
        check(wa == 3'd0, {tag, "_wa"}, 32'(wa), 32'd0);
        check(wd == 32'd0, {tag, "_wd"}, wd, 32'd0);
        check(illegal == 1'b0, {tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            exp_t e;
            bit   mb;
            mb = (cyc >= bs) && (cyc <= be);
            check(busy == mb, "busy", 32'(busy), 32'(mb));
            if (q.size() > 0 && q[0].cyc < cyc) begin
                check(1'b0, "missed_response", 32'(cyc), 32'(q[0].cyc));
                void'(q.pop_front());
            end
            if (we || illegal) begin
                if (q.size() == 0) begin
                    check(1'b0, "unexpected_response", {30'd0, we, illegal}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check(cyc == e.cyc, "latency", 32'(cyc), 32'(e.cyc));
                    check(we == !e.ill, "we", 32'(we), 32'(!e.ill));
                    check(illegal == e.ill, "illegal", 32'(illegal), 32'(e.ill));
                    if (!e.ill) begin
                        check(wa == e.wa, "wa", 32'(wa), 32'(e.wa));
                        check(wd == e.wd, "wd", wd, e.wd);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] x, y;
        int          guard;
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #2 n_rst = 1'b1;

        issue(3'd0, 32'd5, 32'd7, 3'd3);
        issue(3'd1, 32'd3, 32'd5, 3'd1);
        issue(3'd5, 32'hFFFF_FFFF, 32'd1, 3'd2);
        issue(3'd6, 32'd1, 32'h25, 3'd4);
        issue(3'd7, 32'd12345, 32'd6789, 3'd6);
        issue(3'd7, 32'h10000, 32'h10000, 3'd5);
        issue(3'd0, 32'd9, 32'd1, 3'd0);

        // Back-to-back starts: ignored while busy, accepted at the first free edge.
        while (cyc + 1 < free_at) idle();
        drive(1'b1, 3'd7, 32'hDEAD_BEEF, 32'h1234_5679, 3'd7);
        repeat (40) drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, 3'($urandom_range(0, 7)));
        idle();

        // Reset mid-instruction: cycle 15 of a MUL, or the WB cycle of an ALU op.
        while (cyc + 1 < free_at) idle();
        if (MUL_EN) begin
            drive(1'b1, 3'd7, 32'd1000, 32'd1000, 3'd3);
            repeat (14) idle();
        end else begin
            drive(1'b1, 3'd0, 32'd1000, 32'd1000, 3'd3);
        end
        @(posedge clk);
        #2;
        check(busy == 1'b1, "busy_before_reset", 32'(busy), 32'd1);
        n_rst = 1'b0;
        start = 1'b0;
        q.delete();
        bs = 1; be = 0; free_at = 0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #2 n_rst = 1'b1;
        repeat (40) idle();
        issue(3'd0, 32'd1, 32'd1, 3'd2);

        // op=111 followed immediately by ADD.
        while (cyc + 1 < free_at) idle();
        drive(1'b1, 3'd7, 32'd3, 32'd4, 3'd1);
        drive(1'b1, 3'd0, 32'd20, 32'd22, 3'd2);
        idle();

        for (int i = 0; i < 400; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) x = x & 32'hF;
            if ($urandom_range(0, 3) == 0) y = y & 32'h3F;
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            drive(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), x, y, 3'($urandom_range(0, 7)));
        end

        guard = 0;
        while (q.size() > 0 && guard < 60) begin
            idle();
            guard++;
        end
        check(q.size() == 0, "drain", 32'(q.size()), 32'd0);
        repeat (2) idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage of the CPU datapath. It sits directly downstream of the 8-entry register file. It consumes the two read operands (`rd1`, `rd2`) together with the decoded opcode and destination, and computes the result with single-cycle ALU operations or an iterative shift-add multiplier. It drives the register file write port (`wa`, `wd`, `we`) for exactly one cycle per completed instruction.

## Interface
- `WIDTH`, 32: operand/result width; must equal the register file data width.
- `AW`, 3: register address width (8 registers).

- `clk`  in  1  rising-edge clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `start`  in  1  issue request; sampled only when `busy`=0.
- `op`  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SHL, 111 MUL.
- `a`  in  WIDTH  operand A (register file `rd1`).
- `b`  in  WIDTH  operand B (register file `rd2`).
- `dst`  in  AW  destination register number.
- `busy`  out  1  high while an instruction is in flight; the issuing stage holds off.
- `we`  out  1  register file write enable, 1-cycle pulse.
- `wa`  out  AW  register file write address.
- `wd`  out  WIDTH  register file write data.
- `illegal`  out  1  1-cycle pulse on an unsupported opcode.

## Operation
- FSM states: IDLE, MUL, WB.
- IDLE, `start`=1, op≠MUL: latch the result into `wd` and `dst` into `wa`, then go to WB.
- IDLE, `start`=1, op=MUL: latch `a` into the multiplicand, `b` into the multiplier, clear the accumulator and the 5-bit counter, latch `dst` into `wa`, then go to MUL.
- MUL step, once per cycle:
  - if `mplier[0]`, then `acc += mcand` (mod 2^WIDTH);
  - `mcand <<= 1`; `mplier >>= 1`; `cnt++`.
  - After the step with `cnt`=31: `wd ← acc` (including the final add), then go to WB.
- WB: `we`=1 for that cycle, then go to IDLE.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT yields 1 if $signed(a) < $signed(b), else 0.
  - SHL is `a << b[4:0]`, zero fill.
  - MUL yields the low WIDTH bits of the product, which are identical for signed and unsigned operands.
- `busy` = (state ≠ IDLE).
- `start` while `busy`=1 is ignored; no queuing.
- `a`, `b`, `op`, `dst` need only be valid in the cycle `start` is accepted.
- `wa`/`wd` hold their last values after WB until the next accept.
- `dst` is not special-cased; writes to register 0 proceed.

## Timing
- Reset (async, immediate) values: state=IDLE, `busy`=0, `we`=0, `wa`=0, `wd`=0, `illegal`=0, `acc`/`cnt`=0.
- Accept at edge E0 (`start`=1, `busy`=0).
- ALU ops:
  - `we`=1 during the cycle after E0; latency 1.
  - Next accept possible at edge E2, giving issue rate 1 per 2 cycles.
- MUL:
  - 32 cycles in MUL, then `we`=1 during the 33rd cycle after E0.
  - Next accept at E34.
- `busy` rises in the cycle after E0 and falls together with `we`.
- Reset asserted mid-MUL or during WB: the instruction is aborted, no write occurs, and all outputs return to reset values.

## Configuration
- `EXEC_MUL_EN` defined:
  - MUL is implemented as described above.
- `EXEC_MUL_EN` undefined:
  - the multiplier datapath and MUL state are not built;
  - an accepted op=111 pulses `illegal`=1 for one cycle after E0, with `we`=0 and `busy`=0 throughout, so the instruction is dropped;
  - all other ops are unchanged.
- With the macro defined, `illegal` is tied 0.

## Test plan
- ADD a=5, b=7, dst=3 → exactly one `we` pulse one cycle after accept, `wa`=3, `wd`=12; `busy` high only during that cycle.
- SUB a=3, b=5 → `wd`=0xFFFFFFFE; SLT a=0xFFFFFFFF, b=1 → `wd`=1; SHL a=1, b=0x25 (shift 5) → `wd`=0x20.
- MUL (macro on) a=12345, b=6789, dst=6 → `we` at cycle 33 after accept, `wd`=83810205, `wa`=6; a=0x10000, b=0x10000 → `wd`=0.
- `start` pulses with different ops during MUL busy cycles 1..32 → all ignored; only the original MUL result is written; a `start` at the first cycle `busy`=0 is accepted.
- `n_rst` asserted at MUL cycle 15 → all outputs go to 0 immediately; no `we` follows; after release, ADD 1+1 → `wd`=2 at latency 1.
- Macro off, op=111 → `illegal` pulse one cycle after accept, `we` stays 0, and the next ADD is accepted on the following cycle.
